// File: rtl/vslc_pkg.sv
// rtl/vslc_pkg.sv - shared state encoding and constants for the VSLC scan controller
package vslc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_RUN    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FAULT  = 3'd4
  } scan_state_t;

  localparam int         SCAN_CNT_W        = 8;
  localparam logic [7:0] FAULT_OUT_DEFAULT = 8'h00;

endpackage

// File: rtl/vslc_in_sync.sv
// rtl/vslc_in_sync.sv - parameterised-width two-flop synchroniser for asynchronous pins
module vslc_in_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vslc_scan_ctrl.sv
// rtl/vslc_scan_ctrl.sv - PLC scan-cycle sequencer (latch, run core, commit) with watchdog
// Optional edge images enabled by defining VSLC_SCAN_EDGE_EN.
module vslc_scan_ctrl
  import vslc_pkg::*;
#(
  parameter int               IN_W       = 8,
  parameter int               OUT_W      = 8,
  parameter int               WDT_CYCLES = 4096,
  parameter logic [OUT_W-1:0] FAULT_OUT  = OUT_W'(FAULT_OUT_DEFAULT),
  localparam int              AW         = $clog2(OUT_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  scan_tick,
  input  logic                  free_run,
  input  logic [IN_W-1:0]       in_pins,
  input  logic                  core_halt,
  input  logic                  core_fault,
  input  logic                  stage_we,
  input  logic [AW-1:0]         stage_addr,
  input  logic                  stage_d,
  output logic                  core_start,
  output logic                  core_run,
  output logic [IN_W-1:0]       in_image,
  output logic [IN_W-1:0]       in_rise,
  output logic [IN_W-1:0]       in_fall,
  output logic [OUT_W-1:0]      out_pins,
  output logic                  scan_overrun,
  output logic                  wdt_trip,
  output logic [SCAN_CNT_W-1:0] scan_count,
  output logic [2:0]            state_dbg
);

  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  scan_state_t      state, state_nxt;
  logic [IN_W-1:0]  in_sync_q;
  logic [OUT_W-1:0] stage_img;
  logic [OUT_W-1:0] out_reg;
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_expire;

  vslc_in_sync #(.W(IN_W)) u_in_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_pins),
    .q     (in_sync_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    core_run   = 1'b0;
    wdt_expire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ena && (scan_tick || free_run)) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        core_start = 1'b1;
        state_nxt  = ena ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        core_run = 1'b1;
        // a core fault outranks everything; losing ena abandons the scan without commit
        if (core_fault)     state_nxt = ST_FAULT;
        else if (!ena)      state_nxt = ST_IDLE;
        else if (core_halt) state_nxt = ST_COMMIT;
        else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
          state_nxt  = ST_FAULT;
          wdt_expire = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_nxt = (ena && free_run) ? ST_LATCH : ST_IDLE;
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_image     <= '0;
      stage_img    <= '0;
      out_reg      <= '0;
      wdt_cnt      <= '0;
      scan_count   <= '0;
      scan_overrun <= 1'b0;
      wdt_trip     <= 1'b0;
    end else begin
      if (scan_tick && state != ST_IDLE) scan_overrun <= 1'b1;
      if (wdt_expire) wdt_trip <= 1'b1;
      case (state)
        ST_LATCH: begin
          in_image  <= in_sync_q;
          // preload so bits the program never writes keep their committed value
          stage_img <= out_reg;
          wdt_cnt   <= '0;
        end
        ST_RUN: begin
          wdt_cnt <= wdt_cnt + WDT_W'(1);
          if (core_run && stage_we) stage_img[stage_addr] <= stage_d;
        end
        ST_COMMIT: begin
          out_reg    <= stage_img;
          scan_count <= scan_count + SCAN_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_pins  = (state == ST_FAULT) ? FAULT_OUT : out_reg;
  assign state_dbg = 3'(state);

`ifdef VSLC_SCAN_EDGE_EN
  logic [IN_W-1:0] prev_image;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                prev_image <= '0;
    else if (state == ST_LATCH) prev_image <= in_image;
  end

  assign in_rise = in_image & ~prev_image;
  assign in_fall = ~in_image & prev_image;
`else
  assign in_rise = '0;
  assign in_fall = '0;
`endif

endmodule

// File: tb/tb_vslc_scan_ctrl.sv
// tb/tb_vslc_scan_ctrl.sv - directed self-checking bench for vslc_scan_ctrl
module tb_vslc_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       scan_tick;
  logic       free_run;
  logic [7:0] in_pins;
  logic       core_halt;
  logic       core_fault;
  logic       stage_we;
  logic [2:0] stage_addr;
  logic       stage_d;
  logic       core_start;
  logic       core_run;
  logic [7:0] in_image;
  logic [7:0] in_rise;
  logic [7:0] in_fall;
  logic [7:0] out_pins;
  logic       scan_overrun;
  logic       wdt_trip;
  logic [7:0] scan_count;
  logic [2:0] state_dbg;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_start [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vslc_scan_ctrl #(
    .IN_W       (8),
    .OUT_W      (8),
    .WDT_CYCLES (8),
    .FAULT_OUT  (8'h5A)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .scan_tick    (scan_tick),
    .free_run     (free_run),
    .in_pins      (in_pins),
    .core_halt    (core_halt),
    .core_fault   (core_fault),
    .stage_we     (stage_we),
    .stage_addr   (stage_addr),
    .stage_d      (stage_d),
    .core_start   (core_start),
    .core_run     (core_run),
    .in_image     (in_image),
    .in_rise      (in_rise),
    .in_fall      (in_fall),
    .out_pins     (out_pins),
    .scan_overrun (scan_overrun),
    .wdt_trip     (wdt_trip),
    .scan_count   (scan_count),
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b0; scan_tick = 1'b0; free_run = 1'b0;
    core_halt = 1'b0; core_fault = 1'b0; stage_we = 1'b0; stage_addr = 3'd0; stage_d = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_scan();
    scan_tick = 1'b1;
    tick();
    scan_tick = 1'b0;
  endtask

  task automatic stage_write(input logic [2:0] a);
    stage_we = 1'b1; stage_addr = a; stage_d = 1'b1;
    tick();
    stage_we = 1'b0;
  endtask

  task automatic halt_commit();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    tick();
  endtask

  initial begin
    in_pins = 8'h00;
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_out_pins", 32'(out_pins), 32'h00);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_scan_count", 32'(scan_count), 32'd0);
    chk("rst_flags", {30'd0, scan_overrun, wdt_trip}, 32'd0);
    tick();
    rst_n = 1'b1;

    // basic scan
    in_pins = 8'hA5; ena = 1'b1;
    repeat (3) tick();
    start_scan();
    chk("basic_start", 32'(core_start), 32'd1);
    chk("basic_latch", 32'(state_dbg), 32'd1);
    tick();
    chk("basic_run", 32'(core_run), 32'd1);
    chk("basic_start_pulse", 32'(core_start), 32'd0);
    chk("basic_in_image", 32'(in_image), 32'hA5);
    stage_write(3'd3);
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    chk("basic_commit_state", 32'(state_dbg), 32'd3);
    chk("basic_out_h1", 32'(out_pins), 32'h00);
    tick();
    chk("basic_out_h2", 32'(out_pins), 32'h08);
    chk("basic_count", 32'(scan_count), 32'd1);
    chk("basic_idle", 32'(state_dbg), 32'd0);

    // free-running scans
    do_reset();
    ena = 1'b1; free_run = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 12 && core_start !== 1'b1; i++) tick();
      chk("fr_start_seen", 32'(core_start), 32'd1);
      t_start[s] = cyc;
      repeat (5) tick();
      core_halt = 1'b1;
      if (s == 2) free_run = 1'b0;
      tick();
      core_halt = 1'b0;
    end
    tick();
    chk("fr_count", 32'(scan_count), 32'd3);
    chk("fr_idle", 32'(state_dbg), 32'd0);
    chk("fr_gap1", 32'(t_start[1] - t_start[0]), 32'd7);
    chk("fr_gap2", 32'(t_start[2] - t_start[1]), 32'd7);

    // watchdog
    do_reset();
    ena = 1'b1;
    start_scan();
    tick();
    repeat (7) tick();
    chk("wdt_run8_state", 32'(state_dbg), 32'd2);
    chk("wdt_run8_trip", 32'(wdt_trip), 32'd0);
    tick();
    chk("wdt_fault_state", 32'(state_dbg), 32'd4);
    chk("wdt_trip", 32'(wdt_trip), 32'd1);
    chk("wdt_fault_out", 32'(out_pins), 32'h5A);
    chk("wdt_core_run", 32'(core_run), 32'd0);
    ena = 1'b0;
    start_scan();
    tick();
    chk("wdt_hold_state", 32'(state_dbg), 32'd4);
    chk("wdt_hold_start", 32'(core_start), 32'd0);

    // fault and halt together
    do_reset();
    ena = 1'b1;
    start_scan();
    tick();
    core_fault = 1'b1; core_halt = 1'b1;
    tick();
    core_fault = 1'b0; core_halt = 1'b0;
    chk("fh_state", 32'(state_dbg), 32'd4);
    tick();
    chk("fh_count", 32'(scan_count), 32'd0);

    // overrun during RUN
    do_reset();
    ena = 1'b1;
    start_scan();
    tick();
    scan_tick = 1'b1;
    tick();
    scan_tick = 1'b0;
    chk("ovr_flag", 32'(scan_overrun), 32'd1);
    chk("ovr_no_start", 32'(core_start), 32'd0);
    chk("ovr_state", 32'(state_dbg), 32'd2);
    halt_commit();
    chk("ovr_count", 32'(scan_count), 32'd1);

    // ena drop mid-RUN after staging 8'hFF
    start_scan();
    tick();
    for (int b = 0; b < 4; b++) stage_write(3'(b));
    halt_commit();
    chk("ena_prev_out", 32'(out_pins), 32'h0F);
    start_scan();
    tick();
    for (int b = 4; b < 8; b++) stage_write(3'(b));
    ena = 1'b0;
    tick();
    chk("ena_idle", 32'(state_dbg), 32'd0);
    chk("ena_out_kept", 32'(out_pins), 32'h0F);
    chk("ena_count_kept", 32'(scan_count), 32'd2);
    chk("ena_core_run", 32'(core_run), 32'd0);

    // async reset mid-RUN
    ena = 1'b1;
    start_scan();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_dbg), 32'd0);
    chk("arst_out", 32'(out_pins), 32'h00);
    chk("arst_count", 32'(scan_count), 32'd0);
    chk("arst_run", 32'(core_run), 32'd0);
    chk("arst_overrun", 32'(scan_overrun), 32'd0);
    tick();

    // edge images over two scans
    do_reset();
    ena = 1'b1; in_pins = 8'h01;
    repeat (3) tick();
    start_scan();
    tick();
    halt_commit();
    in_pins = 8'h02;
    repeat (3) tick();
    start_scan();
    tick();
    chk("edge_image", 32'(in_image), 32'h02);
`ifdef VSLC_SCAN_EDGE_EN
    chk("edge_rise", 32'(in_rise), 32'h02);
    chk("edge_fall", 32'(in_fall), 32'h01);
`else
    chk("edge_rise", 32'(in_rise), 32'h00);
    chk("edge_fall", 32'(in_fall), 32'h00);
`endif
    halt_commit();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
